traffic_light_monitor: RTL
==========================

# traffic_light_monitor

Passive checker for the receiving side of the four-way traffic controller's light buses. It samples the four 3-bit light outputs every clock and verifies encoding, per-direction sequencing, minimum yellow time, maximum green time and mutual exclusion. It reports violations as sticky error flags with per-direction attribution, and counts completed green phases. It sits beside the controller in integration benches and at the top level as a safety monitor, and never drives the lights.

## Interface
- YELLOW_MIN, 2: minimum number of consecutive yellow samples before a yellow-to-red transition.
- GREEN_MAX, 16: maximum number of consecutive green samples allowed for one direction.
- CNT_W, 8: width of the per-direction dwell counters and of phase_count.

- clk  in  1  rising-edge clock, shared with the controller.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- light_NORTH  in  3  north light; bit2 = red, bit1 = yellow, bit0 = green.
- light_EAST  in  3  east light, same encoding.
- light_WEST  in  3  west light, same encoding.
- light_SOUTH  in  3  south light, same encoding.
- encode_err  out  1  sticky; a non-one-hot value was sampled.
- seq_err  out  1  sticky; an illegal transition or a short yellow was sampled.
- timeout_err  out  1  sticky; a green exceeded GREEN_MAX.
- conflict_err  out  1  sticky; more than one direction was non-red in the same sample.
- err_dir  out  4  sticky per-direction attribution; bit0 = N, bit1 = E, bit2 = W, bit3 = S.
- phase_count  out  CNT_W  number of completed green phases (GREEN->YELLOW), saturating.

## Operation
- Each direction has an independent tracker with states INIT, RED, GREEN, YELLOW, plus a dwell counter (CNT_W bits, saturating).
- Legal values are 3'b100 (RED), 3'b010 (YELLOW) and 3'b001 (GREEN). Any other value sets encode_err and the direction's err_dir bit. The tracker state and counter are held unchanged for that sample.
- INIT: the first legal sample loads that state with counter = 1. No transition check is made.
- Legal transitions:
  - hold: counter increments.
  - RED->GREEN, GREEN->YELLOW, YELLOW->RED: counter reloads to 1.
- Illegal transitions are GREEN->RED, RED->YELLOW and YELLOW->GREEN. Each sets seq_err and err_dir, and the tracker still follows the input.
- Short yellow: on YELLOW->RED, if the counter (number of yellow samples) is below YELLOW_MIN, set seq_err and err_dir.
- Green timeout: when a GREEN hold would take the counter to GREEN_MAX+1, set timeout_err and err_dir. The counter saturates at its maximum value.
- Conflict: if two or more directions sample a legal non-red value (GREEN or YELLOW) in the same cycle, set conflict_err and the err_dir bits of all non-red directions. Illegal encodings do not count toward conflict.
- phase_count increments by 1 for each GREEN->YELLOW transition in any direction. Simultaneous transitions in k directions add k. It saturates at 2^CNT_W-1.
- All error flags and err_dir bits are sticky until reset. Several flags may set in the same cycle.

## Timing
- Reset (reset = 0, asynchronous):
  - trackers go to INIT and counters to 0;
  - all error outputs, err_dir and phase_count go to 0.
  - The block ignores inputs while in reset.
- Reset release takes effect at the first rising edge after reset returns high. Deassertion is assumed synchronous to clk at system level.
- Inputs are sampled on each rising edge. A violation present at edge k is visible on the outputs immediately after edge k (one-cycle latency from the input change, registered outputs). phase_count updates on the same edge.
- Mid-run reset clears everything, and the next legal sample per direction is treated as INIT (no transition check).
- With YELLOW_MIN = 2: the sequence Y,Y,R passes and Y,R fails.
- With GREEN_MAX = 16: 16 consecutive G samples pass, and the 17th sets timeout_err on that edge.

## Test plan
- Reset then legal cycle: reset low for 15 ns, then N: R,G×4,Y×2,R while E, W and S are held at 3'b100. Required: all error flags 0, err_dir = 4'b0000, phase_count = 1.
- Encoding error: drive light_EAST = 3'b011 for one cycle. Required: encode_err = 1 and err_dir = 4'b0010 after that edge, and both stay high with no other flags.
- Sequence errors: N G->R directly, later S Y×1->R. Required: seq_err = 1 and err_dir = 4'b1001.
- Conflict: N = 3'b001 and W = 3'b010 in the same sample. Required: conflict_err = 1 and err_dir = 4'b0101 on that edge.
- Timeout: hold S green for 17 samples with GREEN_MAX = 16. Required: timeout_err rises on the 17th edge, not the 16th, and err_dir = 4'b1000.
- Mid-run reset: assert reset low after errors are set. Required: all outputs 0 asynchronously, before the next edge. After release, a first sample of N = YELLOW is accepted with no seq_err.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Passive safety checker for the four-way traffic controller light buses.
// Tracks each direction's light sequence and raises sticky, direction-attributed error flags.
module traffic_light_monitor #(
    parameter int YELLOW_MIN = 2,
    parameter int GREEN_MAX  = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       light_NORTH,
    input  logic [2:0]       light_EAST,
    input  logic [2:0]       light_WEST,
    input  logic [2:0]       light_SOUTH,
    output logic             encode_err,
    output logic             seq_err,
    output logic             timeout_err,
    output logic             conflict_err,
    output logic [3:0]       err_dir,
    output logic [CNT_W-1:0] phase_count
);

    typedef enum logic [1:0] {ST_INIT, ST_RED, ST_GREEN, ST_YELLOW} trk_state_e;

    localparam logic [2:0]       LT_RED    = 3'b100;
    localparam logic [2:0]       LT_YELLOW = 3'b010;
    localparam logic [2:0]       LT_GREEN  = 3'b001;
    localparam logic [CNT_W-1:0] YMIN_C    = CNT_W'(YELLOW_MIN);
    localparam logic [CNT_W-1:0] GMAX_C    = CNT_W'(GREEN_MAX);

    logic [2:0]       lights [4];
    trk_state_e       state_q [4];
    trk_state_e       state_d [4];
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic             enc_q, enc_d, seq_q, seq_d, tmo_q, tmo_d, cfl_q, cfl_d;
    logic [3:0]       dir_q, dir_d;
    logic [CNT_W-1:0] phase_q, phase_d;

    assign lights[0] = light_NORTH;
    assign lights[1] = light_EAST;
    assign lights[2] = light_WEST;
    assign lights[3] = light_SOUTH;

    function automatic trk_state_e decode(input logic [2:0] l);
        case (l)
            LT_RED:    decode = ST_RED;
            LT_YELLOW: decode = ST_YELLOW;
            LT_GREEN:  decode = ST_GREEN;
            default:   decode = ST_INIT;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        sat_inc = (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    always_comb begin
        trk_state_e       in_st;
        logic             legal;
        logic [3:0]       nonred;
        logic [2:0]       k;
        logic [CNT_W+2:0] psum;

        enc_d  = enc_q;
        seq_d  = seq_q;
        tmo_d  = tmo_q;
        cfl_d  = cfl_q;
        dir_d  = dir_q;
        nonred = 4'b0000;
        k      = 3'd0;
        in_st  = ST_INIT;
        legal  = 1'b0;
        psum   = '0;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            in_st      = decode(lights[i]);
            legal      = (in_st != ST_INIT);
            if (!legal) begin
                enc_d    = 1'b1;
                dir_d[i] = 1'b1;
            end else begin
                nonred[i]  = (in_st != ST_RED);
                state_d[i] = in_st;
                if (state_q[i] == ST_INIT) begin
                    cnt_d[i] = 1;
                end else if (in_st == state_q[i]) begin
                    cnt_d[i] = sat_inc(cnt_q[i]);
                    if (in_st == ST_GREEN && cnt_q[i] >= GMAX_C) begin
                        tmo_d    = 1'b1;
                        dir_d[i] = 1'b1;
                    end
                end else begin
                    // Tracker follows the input even across an illegal step.
                    cnt_d[i] = 1;
                    case ({state_q[i], in_st})
                        {ST_GREEN, ST_YELLOW}: k = k + 3'd1;
                        {ST_YELLOW, ST_RED}: begin
                            if (cnt_q[i] < YMIN_C) begin
                                seq_d    = 1'b1;
                                dir_d[i] = 1'b1;
                            end
                        end
                        {ST_RED, ST_GREEN}: ;
                        default: begin
                            seq_d    = 1'b1;
                            dir_d[i] = 1'b1;
                        end
                    endcase
                end
            end
        end
        if ($countones(nonred) >= 2) begin
            cfl_d = 1'b1;
            dir_d = dir_d | nonred;
        end
        psum = {3'b000, phase_q} + {{CNT_W{1'b0}}, k};
        if (psum > {3'b000, {CNT_W{1'b1}}}) phase_d = {CNT_W{1'b1}};
        else                                phase_d = psum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= ST_INIT;
                cnt_q[i]   <= '0;
            end
            enc_q   <= 1'b0;
            seq_q   <= 1'b0;
            tmo_q   <= 1'b0;
            cfl_q   <= 1'b0;
            dir_q   <= 4'b0000;
            phase_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            enc_q   <= enc_d;
            seq_q   <= seq_d;
            tmo_q   <= tmo_d;
            cfl_q   <= cfl_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
        end
    end

    assign encode_err   = enc_q;
    assign seq_err      = seq_q;
    assign timeout_err  = tmo_q;
    assign conflict_err = cfl_q;
    assign err_dir      = dir_q;
    assign phase_count  = phase_q;

endmodule
